// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcodes and FSM encoding shared by the multiply/divide sequencer
// and the ALU control decode.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    function automatic logic valid_op(input logic [2:0] op);
        return op == OP_MUL || op == OP_DIV;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/result bundle between the execute stage (master)
// and the multiply/divide sequencer (slave).
interface muldiv_sequencer_if #(parameter int WIDTH = 32);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, src_a, src_b, flush,
        input  ready, busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output ready, busy, done, hi, lo, div_zero
    );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or restoring
// divide; {rem, quo} is the MUL accumulator {hi, lo} or the DIV {remainder, quotient}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_s;
    logic           ge;

    always_comb begin
        sum   = {1'b0, rem_i} + (quo_i[0] ? {1'b0, opb_i} : '0);
        rem_s = {rem_i, quo_i[WIDTH-1]};
        ge    = rem_s >= {1'b0, opb_i};
        // a kept remainder is always below the divisor, so WIDTH bits hold it
        rem_o = op == OP_DIV ? (ge ? WIDTH'(rem_s - {1'b0, opb_i}) : rem_s[WIDTH-1:0])
                             : sum[WIDTH:1];
        quo_o = op == OP_DIV ? {quo_i[WIDTH-2:0], ge} : {sum[0], quo_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle unsigned MUL/DIV controller, one bit per cycle,
// with stall (busy), one-cycle done pulse and held hi/lo/div_zero results.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    muldiv_sequencer_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic             accept;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op    (op_q),
        .rem_i (rem_q),
        .quo_i (quo_q),
        .opb_i (opb_q),
        .rem_o (rem_n),
        .quo_o (quo_n)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        accept  = bus.start && valid_op(bus.op) && !bus.flush;
        if (state_q == S_RUN) begin
            if (bus.flush) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    hi_d    = rem_n;
                    lo_d    = quo_n;
                    dz_d    = 1'b0;
                end
            end
        end else if (accept) begin
            op_d    = bus.op;
            opb_d   = bus.src_b;
            rem_d   = '0;
            quo_d   = bus.src_a;
            cnt_d   = CW'(WIDTH);
            state_d = S_RUN;
            // divide by zero never iterates: results are fixed at accept
            if (bus.op == OP_DIV && bus.src_b == '0) begin
                state_d = S_DONE;
                cnt_d   = '0;
                hi_d    = bus.src_a;
                lo_d    = '1;
                dz_d    = 1'b1;
            end
        end else begin
            state_d = S_IDLE;
        end
        busy_d = state_d == S_RUN;
        done_d = state_d == S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opb_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready    = ~busy_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors with a scoreboard of expected results;
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          bc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   bcnt = 0;
    logic prev_done = 1'b0;

    muldiv_sequencer_if #(.WIDTH(32)) bus();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk(!(bus.busy && bus.done), "busy_and_done", {bus.busy, bus.done}, 2'b00);
            if (bus.done) begin
                chk(!prev_done, "done_width", prev_done, 0);
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk(bus.hi == e.hi, "hi", bus.hi, e.hi);
                    chk(bus.lo == e.lo, "lo", bus.lo, e.lo);
                    chk(bus.div_zero == e.dz, "div_zero", bus.div_zero, e.dz);
                    chk(bcnt == e.bc, "busy_cycles", bcnt, e.bc);
                end
                bcnt = 0;
            end else if (bus.busy) begin
                bcnt++;
            end else begin
                bcnt = 0;
            end
        end
        prev_done = bus.done;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // drives a one-cycle start; returns at #1 after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input int ebc);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        if (push) begin
            e.hi = ehi; e.lo = elo; e.dz = edz; e.bc = ebc;
            q.push_back(e);
        end
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!bus.done && n < 100) begin
            step(1);
            n++;
        end
        if (!bus.done) chk(1'b0, {name, "_timeout"}, 0, 1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.flush = 1'b0;
        step(2);
        chk(bus.ready == 1'b1, "rst_ready", bus.ready, 1);
        chk({bus.busy, bus.done, bus.div_zero} == 3'b000, "rst_flags", {bus.busy, bus.done, bus.div_zero}, 0);
        chk({bus.hi, bus.lo} == 64'd0, "rst_hilo", {bus.hi, bus.lo}, 0);
        rst_n = 1'b1;
        step(2);

        issue(3'b001, 32'd7, 32'd6, 1, 32'd0, 32'd42, 1'b0, 32);
        wait_done("mul_basic");
        step(2);
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32);
        wait_done("mul_ovf");
        step(2);
        issue(3'b010, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0, 32);
        wait_done("div");
        step(2);
        issue(3'b010, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
        chk(bus.done == 1'b1, "dz_done_latency", bus.done, 1);
        chk(bus.busy == 1'b0, "dz_no_busy", bus.busy, 0);
        step(2);

        issue(3'b001, 32'd3, 32'd4, 1, 32'd0, 32'd12, 1'b0, 32);
        bus.start = 1'b1;
        bus.op    = 3'b001;
        bus.src_a = 32'd9;
        bus.src_b = 32'd9;
        step(5);
        bus.op    = 3'b010;
        step(3);
        bus.start = 1'b0;
        wait_done("mul_busy_starts");
        step(2);

        issue(3'b001, 32'd5, 32'd5, 0, 0, 0, 0, 0);
        step(9);
        bus.flush = 1'b1;
        step(1);
        bus.flush = 1'b0;
        chk(bus.busy == 1'b0, "flush_busy", bus.busy, 0);
        step(40);
        chk(bus.lo == 32'd12, "flush_lo_held", bus.lo, 12);

        issue(3'b000, 32'd1, 32'd1, 0, 0, 0, 0, 0);
        chk(bus.busy == 1'b0, "invalid_op_busy", bus.busy, 0);
        step(3);
        chk(bus.ready == 1'b1, "invalid_op_ready", bus.ready, 1);

        issue(3'b001, 32'd2, 32'd3, 1, 32'd0, 32'd6, 1'b0, 32);
        wait_done("b2b_first");
        issue(3'b001, 32'd4, 32'd5, 1, 32'd0, 32'd20, 1'b0, 32);
        chk(bus.busy == 1'b1, "b2b_busy", bus.busy, 1);
        wait_done("b2b_second");
        step(2);

        issue(3'b001, 32'd8, 32'd8, 0, 0, 0, 0, 0);
        step(14);
        rst_n = 1'b0;
        #1;
        chk({bus.busy, bus.done} == 2'b00, "rst_mid_flags", {bus.busy, bus.done}, 0);
        chk({bus.hi, bus.lo} == 64'd0, "rst_mid_hilo", {bus.hi, bus.lo}, 0);
        chk(bus.ready == 1'b1, "rst_mid_ready", bus.ready, 1);
        step(2);
        rst_n = 1'b1;
        step(1);
        issue(3'b001, 32'd2, 32'd2, 1, 32'd0, 32'd4, 1'b0, 32);
        wait_done("mul_after_rst");
        step(3);

        chk(q.size() == 0, "scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
